// File: rtl/ciphertext_serializer.sv
`default_nettype none
// ============================================================================
// ciphertext_serializer
//   Buffers (C1,C2) projective ciphertext records captured on the rising edge
//   of Encryption_complete, then streams them one coordinate word per beat.
//   Optional macro CT_CHECKSUM_EN appends a 7th XOR checksum word per record.
// Revision: 1.0
// ============================================================================
module ciphertext_serializer #(
  parameter int N     = 3,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           x_C1,
  input  logic [N-1:0]           y_C1,
  input  logic [N-1:0]           z_C1,
  input  logic [N-1:0]           x_C2,
  input  logic [N-1:0]           y_C2,
  input  logic [N-1:0]           z_C2,
  input  logic                   Encryption_complete,
  output logic [N-1:0]           ct_data,
  output logic [2:0]             ct_idx,
  output logic                   ct_valid,
  input  logic                   ct_ready,
  output logic                   ct_last,
  output logic [$clog2(DEPTH):0] ct_count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef CT_CHECKSUM_EN
  localparam int NW = 7;
`else
  localparam int NW = 6;
`endif
  localparam logic [2:0]    LAST    = 3'(NW - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [PW-1:0]  wr_q, rd_q, rd_d;
  logic [CW-1:0]  count_q, count_d;
  logic           comp_q;
  logic           overflow_q;
  logic [N-1:0]   mem_q [DEPTH][NW];
  logic [N-1:0]   cap_word [NW];

  logic capture;
  logic pop;
  logic accept;

  always_comb begin
    cap_word[0] = x_C1;
    cap_word[1] = y_C1;
    cap_word[2] = z_C1;
    cap_word[3] = x_C2;
    cap_word[4] = y_C2;
    cap_word[5] = z_C2;
`ifdef CT_CHECKSUM_EN
    cap_word[6] = x_C1 ^ y_C1 ^ z_C1 ^ x_C2 ^ y_C2 ^ z_C2;
`endif
  end

  assign capture = Encryption_complete & ~comp_q;
  assign pop     = (state_q == SEND) & ct_ready & (idx_q == LAST);
  // A full buffer still accepts when its head record is leaving this cycle.
  assign accept  = capture & ((count_q < DEPTH_C) | pop);
  assign count_d = count_q + CW'(accept) - CW'(pop);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = SEND;
          idx_d   = 3'd0;
        end
      end
      SEND: begin
        if (ct_ready) begin
          if (idx_q == LAST) begin
            rd_d  = rd_q + PW'(1);
            idx_d = 3'd0;
            if (count_d == '0) state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      comp_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      comp_q     <= Encryption_complete;
      overflow_q <= overflow_q | (capture & ~accept);
      if (accept) wr_q <= wr_q + PW'(1);
    end
  end

  // Record storage carries no reset; only slots covered by count are read.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int w = 0; w < NW; w++) mem_q[wr_q][w] <= cap_word[w];
    end
  end

  assign ct_valid = (state_q == SEND);
  assign ct_data  = ct_valid ? mem_q[rd_q][idx_q] : '0;
  assign ct_idx   = idx_q;
  assign ct_last  = ct_valid & (idx_q == LAST);
  assign ct_count = count_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ciphertext_serializer.sv
`default_nettype none
// ============================================================================
// tb_ciphertext_serializer
//   Directed plus random stimulus against a queue-based record model.
// Revision: 1.0
// ============================================================================
module tb_ciphertext_serializer;

  localparam int N     = 3;
  localparam int DEPTH = 2;
`ifdef CT_CHECKSUM_EN
  localparam int T_LAST = 6;
`else
  localparam int T_LAST = 5;
`endif

  typedef logic [6:0][N-1:0] rec_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N-1:0]           x_C1, y_C1, z_C1, x_C2, y_C2, z_C2;
  logic                   Encryption_complete;
  logic [N-1:0]           ct_data;
  logic [2:0]             ct_idx;
  logic                   ct_valid;
  logic                   ct_ready;
  logic                   ct_last;
  logic [$clog2(DEPTH):0] ct_count;
  logic                   overflow;

  int checks   = 0;
  int failures = 0;

  rec_t recs[$];
  int   m_beat   = 0;
  bit   m_active = 1'b0;
  bit   m_ovf    = 1'b0;
  bit   m_prev   = 1'b0;

  ciphertext_serializer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .x_C1                (x_C1),
    .y_C1                (y_C1),
    .z_C1                (z_C1),
    .x_C2                (x_C2),
    .y_C2                (y_C2),
    .z_C2                (z_C2),
    .Encryption_complete (Encryption_complete),
    .ct_data             (ct_data),
    .ct_idx              (ct_idx),
    .ct_valid            (ct_valid),
    .ct_ready            (ct_ready),
    .ct_last             (ct_last),
    .ct_count            (ct_count),
    .overflow            (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ct(input int a, input int b, input int c,
                        input int d, input int e, input int f);
    x_C1 = N'(a); y_C1 = N'(b); z_C1 = N'(c);
    x_C2 = N'(d); y_C2 = N'(e); z_C2 = N'(f);
  endtask

  task automatic model_reset();
    recs.delete();
    m_beat   = 0;
    m_active = 1'b0;
    m_ovf    = 1'b0;
    m_prev   = 1'b0;
  endtask

  // Predicts the effect of the next rising edge given the inputs now driven.
  task automatic model_step();
    rec_t r;
    bit   cap, pop, acc;
    int   held;
    cap  = Encryption_complete && !m_prev;
    pop  = m_active && ct_ready && (m_beat == T_LAST);
    held = recs.size();
    acc  = cap && ((held < DEPTH) || pop);
    if (cap && !acc) m_ovf = 1'b1;
    if (!m_active) begin
      m_active = (held > 0);
      m_beat   = 0;
    end else if (ct_ready) begin
      if (pop) begin
        void'(recs.pop_front());
        m_beat   = 0;
        m_active = (recs.size() + (acc ? 1 : 0)) > 0;
      end else begin
        m_beat++;
      end
    end
    if (acc) begin
      r    = '0;
      r[0] = x_C1; r[1] = y_C1; r[2] = z_C1;
      r[3] = x_C2; r[4] = y_C2; r[5] = z_C2;
`ifdef CT_CHECKSUM_EN
      r[6] = x_C1 ^ y_C1 ^ z_C1 ^ x_C2 ^ y_C2 ^ z_C2;
`endif
      recs.push_back(r);
    end
    m_prev = Encryption_complete;
  endtask

  task automatic check_outputs();
    rec_t r;
    chk("valid", 32'(ct_valid), 32'(m_active));
    chk("count", 32'(ct_count), 32'(recs.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_active && recs.size() > 0) begin
      r = recs[0];
      chk("data", 32'(ct_data), 32'(r[m_beat]));
      chk("idx", 32'(ct_idx), 32'(m_beat));
      chk("last", 32'(ct_last), 32'(m_beat == T_LAST));
    end else begin
      chk("last_idle", 32'(ct_last), 32'd0);
    end
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic pulse();
    Encryption_complete = 1'b1;
    step();
    Encryption_complete = 1'b0;
    step();
  endtask

  initial begin
    int n;
    reset = 1'b0;
    Encryption_complete = 1'b0;
    ct_ready = 1'b1;
    set_ct(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_data", 32'(ct_data), 32'd0);
    chk("rst_idx", 32'(ct_idx), 32'd0);
    chk("rst_valid", 32'(ct_valid), 32'd0);
    chk("rst_last", 32'(ct_last), 32'd0);
    chk("rst_count", 32'(ct_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;

    // Single record, ready held high
    set_ct(1, 2, 3, 4, 5, 6);
    pulse();
    repeat (10) step();

    // Backpressure at idx 2
    pulse();
    n = 0;
    while (!(m_active && m_beat == 2) && n < 20) begin
      step();
      n++;
    end
    chk("bp_reach", 32'(m_active && m_beat == 2), 32'd1);
    ct_ready = 1'b0;
    repeat (4) begin
      step();
      chk("bp_hold_data", 32'(ct_data), 32'd3);
    end
    ct_ready = 1'b1;
    step();
    chk("bp_resume", 32'(ct_data), 32'd4);
    repeat (10) step();

    // Back-to-back records
    set_ct(1, 2, 3, 4, 5, 6);
    pulse();
    step();
    set_ct(1, 2, 3, 7, 0, 1);
    pulse();
    repeat (16) step();

    // Overflow: three captures against a stalled consumer
    ct_ready = 1'b0;
    set_ct(1, 1, 1, 1, 1, 1); pulse();
    set_ct(2, 2, 2, 2, 2, 2); pulse();
    set_ct(3, 3, 3, 3, 3, 3); pulse();
    step();
    chk("ovf_count", 32'(ct_count), 32'd2);
    chk("ovf_flag", 32'(overflow), 32'd1);
    ct_ready = 1'b1;
    repeat (18) step();

    // Reset in the middle of a record
    set_ct(5, 6, 7, 1, 2, 3);
    pulse();
    n = 0;
    while (!(m_active && m_beat == 3) && n < 20) begin
      step();
      n++;
    end
    chk("mid_reach", 32'(m_active && m_beat == 3), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ct_valid), 32'd0);
    chk("mid_rst_count", 32'(ct_count), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (6) step();

    // Randomized traffic
    repeat (3000) begin
      Encryption_complete = ($urandom_range(0, 3) == 0);
      ct_ready = ($urandom_range(0, 3) != 0);
      set_ct($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      step();
    end
    Encryption_complete = 1'b0;
    ct_ready = 1'b1;
    repeat (30) step();
    chk("drain_count", 32'(ct_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
